// File: rtl/pcd_frame_decoder.sv
// PICC-side receiver for ISO 14443-A 106 kbps PCD->PICC frames.
// Decodes Modified Miller symbols from the demodulated carrier envelope
// into LSB-first bytes with parity, short-frame and error status.
module pcd_frame_decoder #(
    parameter int unsigned QTR_CYCLES = 1,
    parameter int unsigned MAX_BYTES  = 5,
    parameter bit          ODD_PARITY = 1'b1
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             env_in,
    output logic [8*MAX_BYTES-1:0]           data_out,
    output logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
    output logic                             short_frame,
    output logic [MAX_BYTES-1:0]             parity_err,
    output logic                             coding_err,
    output logic                             length_err,
    output logic                             rx_busy,
    output logic                             rx_done
);

    localparam int unsigned PERIOD = 4 * QTR_CYCLES;
    localparam int unsigned CW     = (PERIOD > 2) ? $clog2(PERIOD) : 2;
    localparam int unsigned NBW    = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW     = 8 * MAX_BYTES;
    localparam int unsigned IW     = (DW > 2) ? $clog2(DW) : 1;
    localparam int unsigned HW     = $clog2(8 * QTR_CYCLES + 1);

    localparam logic [CW-1:0]  Q0_END   = CW'(QTR_CYCLES);
    localparam logic [CW-1:0]  Q2_BEG   = CW'(2 * QTR_CYCLES);
    localparam logic [CW-1:0]  Q2_END   = CW'(3 * QTR_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST = CW'(PERIOD - 1);
    localparam logic [HW-1:0]  HI_LAST  = HW'(8 * QTR_CYCLES - 1);
    localparam logic [NBW-1:0] BYTES_MAX = NBW'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOC,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        SYM_X,
        SYM_Y,
        SYM_Z,
        SYM_BAD
    } sym_t;

    state_t          state;
    sym_t            sym;
    sym_t            last_sym;
    logic            env_prev;
    logic [CW-1:0]   cyc;
    logic            low_q0;
    logic            low_q2;
    logic            have_held;
    logic            held_bit;
    logic [NBW-1:0]  byte_idx;
    logic [3:0]      pos;
    logic            par_acc;
    logic [HW-1:0]   hi_cnt;

    logic            in_q0;
    logic            in_q2;
    logic            sym_end;
    logic            coding_hit;
    logic            early_y;
    logic            dec_valid;
    logic            dec_bit;
    logic            overflow;
    logic            frame_end;
    logic [IW-1:0]   commit_idx;
    logic [DW-1:0]   commit_vec;
    logic            parity_bad;
    logic [MAX_BYTES-1:0] par_vec;

    // Symbol classification and per-symbol decode decisions
    always_comb begin
        in_q0      = (cyc < Q0_END);
        in_q2      = (cyc >= Q2_BEG) && (cyc < Q2_END);
        sym_end    = ((state == ST_SOC) || (state == ST_DATA)) && (cyc == CYC_LAST);

        sym = SYM_Y;
        if (low_q0 && low_q2) begin
            sym = SYM_BAD;
        end else if (low_q0) begin
            sym = SYM_Z;
        end else if (low_q2) begin
            sym = SYM_X;
        end

        coding_hit = sym_end && (((state == ST_SOC) && (sym != SYM_Z)) ||
                                 ((state == ST_DATA) && (sym == SYM_BAD)));
        early_y    = sym_end && (state == ST_DATA) && (sym == SYM_Y) && !have_held;
        dec_valid  = sym_end && (state == ST_DATA) &&
                     ((sym == SYM_X) || (sym == SYM_Z) ||
                      ((sym == SYM_Y) && have_held && (last_sym == SYM_X)));
        dec_bit    = (sym == SYM_X);
        overflow   = dec_valid && have_held && (byte_idx == BYTES_MAX);
        frame_end  = sym_end && (state == ST_DATA) && (sym == SYM_Y) &&
                     have_held && (last_sym != SYM_X);

        commit_idx = IW'({byte_idx, 3'b000}) + IW'(pos);
        commit_vec = DW'(held_bit) << commit_idx;
        parity_bad = par_acc ^ held_bit ^ ODD_PARITY;
        par_vec    = MAX_BYTES'(parity_bad) << byte_idx;
    end

    // Frame FSM: symbol timing, bit commit, status and handshake outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            env_prev    <= 1'b0;
            cyc         <= '0;
            low_q0      <= 1'b0;
            low_q2      <= 1'b0;
            last_sym    <= SYM_Y;
            have_held   <= 1'b0;
            held_bit    <= 1'b0;
            byte_idx    <= '0;
            pos         <= '0;
            par_acc     <= 1'b0;
            hi_cnt      <= '0;
            data_out    <= '0;
            num_bytes   <= '0;
            short_frame <= 1'b0;
            parity_err  <= '0;
            coding_err  <= 1'b0;
            length_err  <= 1'b0;
            rx_busy     <= 1'b0;
            rx_done     <= 1'b0;
        end else begin
            env_prev <= env_in;
            rx_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // The detecting cycle is cyc=0 of the start symbol, already low in q0
                    if (env_prev && !env_in) begin
                        state       <= ST_SOC;
                        cyc         <= CW'(1);
                        low_q0      <= 1'b1;
                        low_q2      <= 1'b0;
                        have_held   <= 1'b0;
                        held_bit    <= 1'b0;
                        byte_idx    <= '0;
                        pos         <= '0;
                        par_acc     <= 1'b0;
                        data_out    <= '0;
                        num_bytes   <= '0;
                        short_frame <= 1'b0;
                        parity_err  <= '0;
                        coding_err  <= 1'b0;
                        length_err  <= 1'b0;
                        rx_busy     <= 1'b1;
                    end
                end

                ST_SOC, ST_DATA: begin
                    if (!sym_end) begin
                        cyc <= cyc + 1'b1;
                        if (in_q0 && !env_in) low_q0 <= 1'b1;
                        if (in_q2 && !env_in) low_q2 <= 1'b1;
                    end else begin
                        cyc      <= '0;
                        low_q0   <= 1'b0;
                        low_q2   <= 1'b0;
                        last_sym <= sym;

                        if (coding_hit || early_y || overflow) begin
                            if (coding_hit) coding_err <= 1'b1;
                            if (early_y || overflow) length_err <= 1'b1;
                            state   <= ST_ERR;
                            hi_cnt  <= '0;
                            rx_done <= 1'b1;
                            rx_busy <= 1'b0;
                        end else if (state == ST_SOC) begin
                            state <= ST_DATA;
                        end else if (frame_end) begin
                            // The held bit is the end-of-communication zero and is dropped
                            state   <= ST_DONE;
                            rx_done <= 1'b1;
                            rx_busy <= 1'b0;
                            if ((byte_idx == '0) && (pos == 4'd7)) begin
                                short_frame <= 1'b1;
                                num_bytes   <= NBW'(1);
                                parity_err  <= '0;
                            end else if ((pos == 4'd0) && (byte_idx != '0)) begin
                                num_bytes <= byte_idx;
                            end else begin
                                length_err <= 1'b1;
                                num_bytes  <= byte_idx;
                            end
                        end else if (dec_valid) begin
                            held_bit  <= dec_bit;
                            have_held <= 1'b1;
                            if (have_held) begin
                                if (pos == 4'd8) begin
                                    parity_err <= parity_err | par_vec;
                                    pos        <= '0;
                                    byte_idx   <= byte_idx + 1'b1;
                                end else begin
                                    data_out <= data_out | commit_vec;
                                    par_acc  <= (pos == 4'd0) ? held_bit : (par_acc ^ held_bit);
                                    pos      <= pos + 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    if (env_in) begin
                        if (hi_cnt == HI_LAST) begin
                            state  <= ST_IDLE;
                            hi_cnt <= '0;
                        end else begin
                            hi_cnt <= hi_cnt + 1'b1;
                        end
                    end else begin
                        hi_cnt <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
